// File: rtl/siete_segmentos_a_bcd.sv
// ============================================================================
// Module   : siete_segmentos_a_bcd
// Purpose  : Qualifies sampled seven-segment lines and decodes them to BCD.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module siete_segmentos_a_bcd #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic [3:0] digit,
  output logic       valid,
  output logic       blank,
  output logic       err,
  output logic       update,
  output logic [7:0] change_count
);

  localparam logic [7:0] C_SAT = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [6:0] w_p;
  logic [6:0] r_s;
  logic [6:0] r_cp;
  logic [7:0] r_cnt;
  logic       w_same;
  logic       w_stable;
  logic       w_commit;
  logic       w_new;
  logic [3:0] w_dig;
  logic       w_isdig;
  logic       w_isblank;

  assign w_p      = {a, b, c, d, e, f, g} ^ {7{ACTIVE_LOW}};
  assign w_same   = (w_p == r_s);
  // The current sample is the (STABLE_CYCLES+1)th identical one in a row.
  assign w_stable = w_same && (r_cnt == C_SAT);

  always_comb begin
    w_dig     = 4'd0;
    w_isdig   = 1'b1;
    w_isblank = 1'b0;
    case (w_p)
      7'b1111110: w_dig = 4'd0;
      7'b0110000: w_dig = 4'd1;
      7'b1101101: w_dig = 4'd2;
      7'b1111001: w_dig = 4'd3;
      7'b0110011: w_dig = 4'd4;
      7'b1011011: w_dig = 4'd5;
      7'b1011111: w_dig = 4'd6;
      7'b1110000: w_dig = 4'd7;
      7'b1111111: w_dig = 4'd8;
      7'b1111011: w_dig = 4'd9;
      7'b0000000: begin
        w_isdig   = 1'b0;
        w_isblank = 1'b1;
      end
      default:    w_isdig = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    w_new    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_stable) begin
          w_commit = 1'b1;
          w_new    = 1'b1;
          w_next   = LOCKED;
        end
      end
      SETTLE: begin
        if (w_stable) begin
          w_commit = 1'b1;
          w_new    = (w_p != r_cp);
          w_next   = LOCKED;
        end
      end
      LOCKED: begin
        if (w_p != r_cp) w_next = SETTLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s          <= 7'd0;
      r_cnt        <= 8'd0;
      r_cp         <= 7'd0;
      digit        <= 4'd0;
      valid        <= 1'b0;
      blank        <= 1'b0;
      err          <= 1'b0;
      update       <= 1'b0;
      change_count <= 8'd0;
    end else begin
      r_s    <= w_p;
      update <= w_commit && w_new;
      if (!w_same)            r_cnt <= 8'd0;
      else if (r_cnt != C_SAT) r_cnt <= r_cnt + 8'd1;
      if (w_commit) begin
        r_cp  <= w_p;
        digit <= w_dig;
        valid <= w_isdig;
        blank <= w_isblank;
        err   <= !w_isdig && !w_isblank;
        if (w_new) change_count <= change_count + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_siete_segmentos_a_bcd.sv
// ============================================================================
// Module   : tb_siete_segmentos_a_bcd
// Purpose  : Directed-vector bench for siete_segmentos_a_bcd (both polarities).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_siete_segmentos_a_bcd;

  logic       clk;
  logic       rst;
  logic [6:0] seg_h;
  logic [6:0] seg_l;

  logic [3:0] digit_h, digit_l;
  logic       valid_h, valid_l, blank_h, blank_l, err_h, err_l;
  logic       update_h, update_l;
  logic [7:0] count_h, count_l;

  int n_checks = 0;
  int n_errors = 0;

  assign seg_l = ~seg_h;

  siete_segmentos_a_bcd #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b0)) u_dut_h (
    .clk(clk), .rst(rst),
    .a(seg_h[6]), .b(seg_h[5]), .c(seg_h[4]), .d(seg_h[3]),
    .e(seg_h[2]), .f(seg_h[1]), .g(seg_h[0]),
    .digit(digit_h), .valid(valid_h), .blank(blank_h), .err(err_h),
    .update(update_h), .change_count(count_h)
  );

  siete_segmentos_a_bcd #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) u_dut_l (
    .clk(clk), .rst(rst),
    .a(seg_l[6]), .b(seg_l[5]), .c(seg_l[4]), .d(seg_l[3]),
    .e(seg_l[2]), .f(seg_l[1]), .g(seg_l[0]),
    .digit(digit_l), .valid(valid_l), .blank(blank_l), .err(err_l),
    .update(update_l), .change_count(count_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] dg, input logic v,
                            input logic bl, input logic er, input logic up,
                            input logic [7:0] cnt);
    check({tag, "_digit"},  {4'd0, digit_h}, {4'd0, dg});
    check({tag, "_valid"},  {7'd0, valid_h}, {7'd0, v});
    check({tag, "_blank"},  {7'd0, blank_h}, {7'd0, bl});
    check({tag, "_err"},    {7'd0, err_h},   {7'd0, er});
    check({tag, "_update"}, {7'd0, update_h}, {7'd0, up});
    check({tag, "_count"},  count_h, cnt);
  endtask

  initial begin
    rst   = 1'b1;
    seg_h = 7'b0000000;
    step(2);
    check_outs("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;

    // Digit 0: committed on the 5th edge after it is first sampled.
    seg_h = 7'b1111110;
    step(4);
    check("d0_pre_valid", {7'd0, valid_h}, 8'd0);
    step(1);
    check_outs("d0", 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    check("d0_al_valid", {7'd0, valid_l}, 8'd1);
    check("d0_al_digit", {4'd0, digit_l}, 8'd0);
    step(1);
    check("d0_update_clear", {7'd0, update_h}, 8'd0);

    // Digit 2: outputs hold digit 0 while settling.
    seg_h = 7'b1101101;
    step(4);
    check_outs("d2_hold", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    step(1);
    check_outs("d2", 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    check("d2_al_digit", {4'd0, digit_l}, 8'd2);

    // Lock on 8, then a two-cycle glitch to 9 that returns to 8.
    seg_h = 7'b1111111;
    step(5);
    check_outs("d8", 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
    step(1);
    seg_h = 7'b1111011;
    step(2);
    seg_h = 7'b1111111;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_outs("glitch", 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    end

    // Illegal pattern, then blank.
    seg_h = 7'b1000001;
    step(5);
    check_outs("illegal", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd4);
    check("illegal_al_err", {7'd0, err_l}, 8'd1);
    seg_h = 7'b0000000;
    step(5);
    check_outs("blank", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5);
    check("blank_al_blank", {7'd0, blank_l}, 8'd1);

    // Reset asserted mid-settle, between clock edges.
    seg_h = 7'b1111110;
    step(2);
    #2 rst = 1'b1;
    #1;
    check_outs("async_rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    check("async_rst_al_count", count_l, 8'd0);
    #2 rst = 1'b0;

    // 256 alternating commits of 3 and 7: the counter wraps to 0.
    for (int i = 0; i < 256; i++) begin
      seg_h = (i % 2 == 0) ? 7'b1111001 : 7'b1110000;
      step(5);
      check("wrap_update", {7'd0, update_h}, 8'd1);
      check("wrap_count", count_h, 8'((i + 1) % 256));
      check("wrap_digit", {4'd0, digit_h}, (i % 2 == 0) ? 8'd3 : 8'd7);
    end
    check("wrap_al_count", count_l, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/siete_segmentos_a_bcd.md
Name: siete_segmentos_a_bcd

Overview:
- Receive-side counterpart of the seven-segment drivers: samples the segment lines a..g, waits until a pattern has been stable for STABLE_CYCLES clocks, then decodes it back to a BCD digit.
- Flags blank and illegal patterns, and counts committed pattern changes.
- Used as a checker/monitor behind display drivers in benches and as a front end for segment-scraping logic.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical samples required before a pattern is committed; legal range 2..255.
- ACTIVE_LOW, 0, 1 = segment lines are active-low (inverted internally before decoding); 0 = active-high.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- a..g  input  1 each  segment lines, bit order {a,b,c,d,e,f,g}, a = MSB
- digit  output  4  committed BCD digit 0..9; 4'd0 when not valid
- valid  output  1  level; committed pattern is a legal decimal digit
- blank  output  1  level; committed pattern is all segments off
- err  output  1  level; committed pattern is neither a digit nor blank
- update  output  1  one-cycle pulse on the edge a new, different pattern is committed
- change_count  output  8  number of commits with update=1, wraps 255->0

Behaviour:
- Reset (async, any time, including mid-settle):
  - digit=0, valid=0, blank=0, err=0, update=0, change_count=0.
  - State IDLE; sample register and stability counter cleared; no pattern committed.
- Normalisation: p = {a..g}, XOR 7'h7F when ACTIVE_LOW=1.
- Decode table (abcdefg, active-high): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Blank = 0000000.
  - Every other code is an error.
- Sampling:
  - Each edge, s <= p.
  - cnt <= (p==s) ? cnt+1 : 0. cnt saturates at STABLE_CYCLES-1.
- States:
  - IDLE: no committed pattern.
  - SETTLE: candidate pattern differs from the committed one and is being qualified.
  - LOCKED: p equals the committed pattern.
- Commit rule:
  - Pattern P first sampled at edge k and held through edge k+STABLE_CYCLES-1 is committed at edge k+STABLE_CYCLES.
  - digit/valid/blank/err reflect P after that edge, so latency is STABLE_CYCLES+1 edges from the first sample.
- Transitions:
  - IDLE -> LOCKED on commit. This is always a new pattern: update=1, change_count+1.
  - LOCKED -> SETTLE when p differs from the committed pattern.
  - SETTLE -> LOCKED on commit.
    - If P differs from the previously committed pattern: update=1, change_count+1.
    - If P equals it (glitch returned): no update, no count.
  - SETTLE, sample differs from s: cnt restarts at 0 and the new sample becomes the candidate. Committed outputs are held unchanged throughout SETTLE.
- Output exclusivity: exactly one of valid/blank/err is 1 whenever a pattern is committed; all three are 0 in IDLE.
- update is registered and high for exactly one cycle per qualifying commit. Back-to-back commits yield separate pulses at least STABLE_CYCLES+1 edges apart.
- change_count: 8-bit modulo-256 counter; 255 + 1 -> 0 with update still asserted.

Test Plan:
- Reset then hold 1111110 (ACTIVE_LOW=0, STABLE_CYCLES=4) for 6 clocks -> at edge 4 after first sample: digit=0, valid=1, update=1 for one cycle, change_count=1.
- After digit 0, switch to 1101101 -> digit=2 after 4 edges, update pulse, change_count=2; outputs stay at digit 0 until then.
- Glitch while locked on 8 (1111111): 1111011 for 2 clocks, then back to 1111111 -> digit stays 8, valid=1 throughout, no update, count unchanged.
- Illegal 1000001 held 5 clocks -> err=1, valid=0, blank=0, digit=0. Then 0000000 -> blank=1, err=0. Both commits pulse update.
- ACTIVE_LOW=1, drive 0000001 (digit 0 inverted) -> digit=0, valid=1. Assert rst mid-settle -> all outputs 0 immediately (asynchronously), state IDLE.
- Cycle through 256 distinct commits (alternating 3/7) -> change_count wraps to 0 on the 256th commit with update=1.
